// File: rtl/multi_countdown_timer.sv
// Bank of independent countdown timers driven by one shared free-running prescaler.
// Optional periodic auto-reload per channel is compiled in with `define TIMER_RELOAD_EN.
module multi_countdown_timer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CLK_DIV  = 6104
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       pause,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       reload,
    output logic                      tick,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expired
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_t;

    logic [PW-1:0] presc;

    // Tick is registered one cycle early so it is high exactly while presc == 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= PW'(CLK_DIV - 1);
            tick  <= 1'b0;
        end else begin
            if (presc == '0) presc <= PW'(CLK_DIV - 1);
            else             presc <= presc - PW'(1);
            tick <= (presc == PW'(1));
        end
    end

`ifndef TIMER_RELOAD_EN
    logic unused_reload;
    assign unused_reload = ^reload;
`endif

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] ld;
        logic             dn;
        logic             ex;
`ifdef TIMER_RELOAD_EN
        logic [WIDTH-1:0] latched;
`endif

        assign ld = load_value[i*WIDTH +: WIDTH];

        // Priority: reset > start > pause > tick; a tick on a start/pause/resume cycle is dropped.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state <= ST_IDLE;
                cnt   <= '0;
                dn    <= 1'b0;
                ex    <= 1'b0;
`ifdef TIMER_RELOAD_EN
                latched <= '0;
`endif
            end else begin
                ex <= 1'b0;
                if (start[i]) begin
                    cnt <= ld;
`ifdef TIMER_RELOAD_EN
                    latched <= ld;
`endif
                    if (ld == '0) begin
                        state <= ST_DONE;
                        dn    <= 1'b1;
                        ex    <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                        dn    <= 1'b0;
                    end
                end else begin
                    case (state)
                        ST_RUN: begin
                            if (pause[i]) begin
                                state <= ST_PAUSED;
                            end else if (tick) begin
                                if (cnt > WIDTH'(1)) begin
                                    cnt <= cnt - WIDTH'(1);
                                end else if (cnt == WIDTH'(1)) begin
                                    ex <= 1'b1;
`ifdef TIMER_RELOAD_EN
                                    if (reload[i] && latched != '0) begin
                                        cnt <= latched;
                                    end else begin
`else
                                    begin
`endif
                                        cnt   <= '0;
                                        state <= ST_DONE;
                                        dn    <= 1'b1;
                                    end
                                end
                            end
                        end
                        ST_PAUSED: begin
                            if (!pause[i]) state <= ST_RUN;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt;
        assign done[i]                 = dn;
        assign expired[i]              = ex;
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Randomized and scripted bench for multi_countdown_timer against a cycle-level
// behavioural model of the timer bank (CLK_DIV=4, WIDTH=4, CHANNELS=2).
module tb_multi_countdown_timer;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned CD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     start;
    logic [CH-1:0]     pause;
    logic [CH*W-1:0]   load_value;
    logic [CH-1:0]     reload;
    logic              tick;
    logic [CH*W-1:0]   count;
    logic [CH-1:0]     done;
    logic [CH-1:0]     expired;

    multi_countdown_timer #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .CLK_DIV (CD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .load_value(load_value),
        .reload    (reload),
        .tick      (tick),
        .count     (count),
        .done      (done),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: cycles since reset, plus per-channel remaining ticks and activity flags.
    int k;
    bit m_tick;
    int m_cnt   [CH];
    int m_latch [CH];
    bit m_run   [CH];
    bit m_hold  [CH];
    bit m_done  [CH];
    bit m_exp   [CH];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit cur_tick;
        int ld;
        if (!reset) begin
            k = 0;
            m_tick = 1'b0;
            for (int c = 0; c < int'(CH); c++) begin
                m_cnt[c] = 0; m_latch[c] = 0; m_run[c] = 0;
                m_hold[c] = 0; m_done[c] = 0; m_exp[c] = 0;
            end
            return;
        end
        cur_tick = ((k % CD) == CD - 1);
        for (int c = 0; c < int'(CH); c++) begin
            m_exp[c] = 1'b0;
            ld = int'(load_value[c*W +: W]);
            if (start[c]) begin
                m_cnt[c]   = ld;
                m_latch[c] = ld;
                m_hold[c]  = 1'b0;
                m_run[c]   = (ld != 0);
                m_done[c]  = (ld == 0);
                m_exp[c]   = (ld == 0);
            end else if (m_run[c] && m_hold[c]) begin
                if (!pause[c]) m_hold[c] = 1'b0;
            end else if (m_run[c]) begin
                if (pause[c]) begin
                    m_hold[c] = 1'b1;
                end else if (cur_tick && m_cnt[c] > 0) begin
                    m_cnt[c] = m_cnt[c] - 1;
                    if (m_cnt[c] == 0) begin
                        m_exp[c] = 1'b1;
`ifdef TIMER_RELOAD_EN
                        if (reload[c] && m_latch[c] != 0) m_cnt[c] = m_latch[c];
`endif
                        if (m_cnt[c] == 0) begin
                            m_run[c]  = 1'b0;
                            m_done[c] = 1'b1;
                        end
                    end
                end
            end
        end
        k++;
        m_tick = ((k % CD) == CD - 1);
    endtask

    task automatic compare_all();
        check("tick", int'(tick), int'(m_tick));
        for (int c = 0; c < int'(CH); c++) begin
            check($sformatf("count%0d", c), int'(count[c*W +: W]), m_cnt[c]);
            check($sformatf("done%0d", c), int'(done[c]), int'(m_done[c]));
            check($sformatf("expired%0d", c), int'(expired[c]), int'(m_exp[c]));
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) advance();
    endtask

    task automatic set_load(input int c, input int v);
        load_value[c*W +: W] = W'(v);
    endtask

    task automatic pulse(input logic [CH-1:0] s);
        start = s;
        advance();
        start = '0;
    endtask

    initial begin
        reset = 1'b0; start = 2'b11; pause = '0; reload = '0;
        load_value = 8'h5A;
        run(3);
        reset = 1'b1; start = '0;
        run(2);

        // One-shot on ch0, ch1 left idle
        set_load(0, 3);
        pulse(2'b01);
        run(20);

        // Pause across several ticks after the first decrement
        set_load(0, 5);
        pulse(2'b01);
        for (int g = 0; g < 40 && m_cnt[0] != 4; g++) advance();
        check("pause_wait", m_cnt[0], 4);
        pause = 2'b01;
        run(10);
        pause = '0;
        run(30);

        // Restart mid-run, then zero load
        set_load(1, 6);
        pulse(2'b10);
        run(10);
        set_load(1, 2);
        pulse(2'b10);
        run(12);
        set_load(1, 0);
        pulse(2'b10);
        run(3);

        // Simultaneous starts; start together with pause
        set_load(0, 1); set_load(1, 2);
        pulse(2'b11);
        run(12);
        set_load(0, 3);
        pause = 2'b01;
        pulse(2'b01);
        run(4);
        pause = '0;
        run(16);

        // Auto-reload, drop reload, reset mid-run
        reload = 2'b01;
        set_load(0, 2);
        pulse(2'b01);
        run(30);
        reload = '0;
        run(12);
        reload = 2'b11;
        set_load(0, 3); set_load(1, 5);
        pulse(2'b11);
        run(7);
        reset = 1'b0;
        advance();
        reset = 1'b1;
        run(5);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < int'(CH); c++) begin
                start[c] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 5) == 0) pause[c] = ~pause[c];
                if ($urandom_range(0, 19) == 0) reload[c] = ~reload[c];
                if ($urandom_range(0, 7) == 0) set_load(c, 0);
                else                           set_load(c, int'($urandom_range(1, 15)));
            end
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
